ifetch_buffer: RTL and testbench
================================

// Module: ifetch_buffer
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC logic. Takes the word address
//  (PC) each cycle, issues an instruction-memory read, and holds returned words in an
//  in-order buffer of DEPTH entries. Each instruction is presented to decode with its PC
//  and its 26-bit jump field; pclogic consumes the jump field as Instruction[25:0].
//  flush, driven by branch/jump resolution, discards stale fetches.
// PARAMETERS
//  DEPTH   4   buffer entries and max requests in flight; power of 2, >= 2
//  AW      32  PC / imem address width (word address; PC steps by 1)
//  DW      32  instruction width
// PORTS
//  clk          in   1    single clock; all state on posedge
//  reset        in   1    synchronous, active-high; clears all state
//  pc_in        in   AW   fetch address from pclogic (aout)
//  pc_valid     in   1    pc_in is a fetch request
//  pc_ready     out  1    request accepted this cycle when pc_valid & pc_ready
//  flush        in   1    redirect (pcsel|jump taken): drop all buffered/in-flight words
//  imem_req     out  1    read strobe = pc_valid & pc_ready
//  imem_addr    out  AW   = pc_in (combinational pass-through)
//  imem_rvalid  in   1    read data valid; responses in order, >= 1 cycle after imem_req
//  imem_rdata   in   DW   read data
//  instr_valid  out  1    head entry filled
//  instr_ready  in   1    decode accepts head entry
//  instr_data   out  DW   head instruction
//  instr_pc     out  AW   PC of head instruction
//  jump_field   out  26   instr_data[25:0]
// BEHAVIOUR
//  - Reset: head/tail/fill ptrs = 0, discard_cnt = 0, filled bits = 0; instr_valid = 0,
//    pc_ready = 0 and imem_req = 0 while reset is high. imem is reset on the same reset,
//    so no response arrives for pre-reset requests.
//  - Pointers are log2(DEPTH)+1 bits, wrap mod 2*DEPTH; alloc = tail - head.
//  - pc_ready = !reset & !flush & (alloc + discard_cnt < DEPTH). Uses registered counts
//    only: a pop in the same cycle does not free a slot (no bypass).
//  - Accept: write pc_in to entry[tail], clear filled[tail], tail++.
//  - Response (imem_rvalid): if discard_cnt != 0, decrement and drop the data; else
//    write data to entry[fill], set filled[fill], fill++.
//  - Pop (instr_valid & instr_ready): head++. instr_valid = filled[head] & (alloc != 0).
//  - Latency: accept at cycle N, rvalid at N+k (k >= 1), instr_valid at N+k+1. Min 2.
//  - Throughput: 1 instr/cycle sustained when imem returns 1/cycle and decode is ready.
//  - flush at cycle N: next cycle head = tail = fill = 0, all filled = 0,
//    discard_cnt += (tail - fill) in-flight count. A response arriving in cycle N is
//    counted in that in-flight count and is dropped. No accept in cycle N.
//    instr_valid = 0 at N+1. Any pop in cycle N is ignored by decode (flush wins).
//  - Requests after flush may issue while discard_cnt != 0. In-order return guarantees
//    stale words arrive first.
//  - Full: alloc + discard_cnt == DEPTH -> pc_ready = 0; pclogic must hold aout.
//  - imem_rvalid with no in-flight request is illegal (assertion).
// STRUCTURE
//  - Package ifetch_pkg: DEPTH, AW, DW defaults; JUMP_FIELD_W = 26;
//    typedef fetch_entry_t {pc, data, filled}.
//  - Sub-module ifetch_ptr_ctrl: pointer/discard counter and ready logic.
//    Entry storage stays in ifetch_buffer.
// TESTING
//  1 Reset: reset=1 for 2 cycles with pc_valid=1 -> pc_ready=0, imem_req=0,
//    instr_valid=0; first accept in the cycle after reset drops.
//  2 Streaming: PC 0..7, imem latency 1, instr_ready=1 -> imem_req every cycle;
//    instr_pc 0..7 in order, 2 cycles after each accept; no bubbles.
//  3 Backpressure: instr_ready=0, DEPTH=4, PC 0x10.. -> exactly 4 accepts, then
//    pc_ready=0; one pop -> pc_ready=1 next cycle; data order preserved.
//  4 Flush with 2 in flight (latency 3): flush -> instr_valid=0 next cycle; the 2 stale
//    rvalids dropped; new PC 0x40 fetched after flush -> first instr_pc=0x40.
//  5 Simultaneous: flush in the same cycle as rvalid and pc_valid -> no accept, response
//    dropped, discard_cnt correct; jump_field == instr_data[25:0] on every output word.
//  6 Reset mid-operation with 3 entries buffered -> all state cleared next cycle;
//    instr_valid=0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared parameters and the buffer entry type for the instruction-fetch stage.
package ifetch_pkg;
  localparam int DEPTH        = 4;
  localparam int AW           = 32;
  localparam int DW           = 32;
  localparam int JUMP_FIELD_W = 26;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
    logic          filled;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_buffer_chk.sv
// Protocol checks for the fetch buffer's instruction-memory interface.
module ifetch_buffer_chk #(
  parameter int PW = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          imem_rvalid,
  input logic [PW:0]   in_flight
);
  // A read response is only legal while some request (live or stale) is outstanding
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (in_flight != {(PW+1){1'b0}}));
endmodule

// File: rtl/ifetch_ptr_ctrl.sv
// Head/tail/fill pointers, stale-response discard counter and request-ready logic
// for the fetch buffer.
module ifetch_ptr_ctrl #(
  parameter int DEPTH = ifetch_pkg::DEPTH,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          pc_valid,
  input  logic          imem_rvalid,
  input  logic          pop,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [PW-1:0] fill,
  output logic [PW-1:0] alloc,
  output logic          pc_ready,
  output logic          accept,
  output logic          fill_we,
  output logic [PW:0]   in_flight
);
  import ifetch_pkg::*;

  localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] ZERO    = {PW{1'b0}};
  localparam logic [PW-1:0] ONE     = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] head_r, tail_r, fill_r, discard_r;
  logic [PW-1:0] head_s, tail_s, fill_s, discard_s;
  logic [PW-1:0] pending_s;
  logic [PW:0]   occupancy_s;
  logic          drop_s;

  // Occupancy and handshake decode from registered counts only (a pop never frees a slot early)
  always_comb begin
    alloc       = tail_r - head_r;
    pending_s   = tail_r - fill_r;
    occupancy_s = {1'b0, alloc} + {1'b0, discard_r};
    in_flight   = {1'b0, pending_s} + {1'b0, discard_r};
    pc_ready    = !reset && !flush && (occupancy_s < DEPTH_W);
    accept      = pc_valid && pc_ready;
    drop_s      = imem_rvalid && (discard_r != ZERO);
    fill_we     = imem_rvalid && (discard_r == ZERO) && !flush;
  end

  // Next-state pointers; on flush every outstanding request still to return becomes a discard
  always_comb begin
    head_s    = head_r;
    tail_s    = tail_r;
    fill_s    = fill_r;
    discard_s = discard_r;
    if (flush) begin
      head_s    = ZERO;
      tail_s    = ZERO;
      fill_s    = ZERO;
      // a response landing in the flush cycle is itself one of the outstanding requests
      discard_s = discard_r + pending_s - {{(PW-1){1'b0}}, imem_rvalid};
    end else begin
      if (accept) tail_s = tail_r + ONE;
      else        tail_s = tail_r;
      if (fill_we) fill_s = fill_r + ONE;
      else         fill_s = fill_r;
      if (drop_s) discard_s = discard_r - ONE;
      else        discard_s = discard_r;
      if (pop) head_s = head_r + ONE;
      else     head_s = head_r;
    end
  end

  // Pointer and discard-count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r    <= ZERO;
      tail_r    <= ZERO;
      fill_r    <= ZERO;
      discard_r <= ZERO;
    end else begin
      head_r    <= head_s;
      tail_r    <= tail_s;
      fill_r    <= fill_s;
      discard_r <= discard_s;
    end
  end

  assign head = head_r;
  assign tail = tail_r;
  assign fill = fill_r;
endmodule

// File: rtl/ifetch_buffer.sv
// In-order instruction-fetch buffer: issues imem reads for incoming PCs and presents
// returned words to decode with their PC and jump field; flush drops stale fetches.
module ifetch_buffer #(
  parameter int DEPTH = ifetch_pkg::DEPTH,
  parameter int AW    = ifetch_pkg::AW,
  parameter int DW    = ifetch_pkg::DW
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [AW-1:0]                       pc_in,
  input  logic                                pc_valid,
  output logic                                pc_ready,
  input  logic                                flush,
  output logic                                imem_req,
  output logic [AW-1:0]                       imem_addr,
  input  logic                                imem_rvalid,
  input  logic [DW-1:0]                       imem_rdata,
  output logic                                instr_valid,
  input  logic                                instr_ready,
  output logic [DW-1:0]                       instr_data,
  output logic [AW-1:0]                       instr_pc,
  output logic [ifetch_pkg::JUMP_FIELD_W-1:0] jump_field
);
  import ifetch_pkg::*;

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  fetch_entry_t  entries_r [DEPTH];
  logic [PW-1:0] head_s, tail_s, fill_s, alloc_s;
  logic [PW:0]   in_flight_s;
  logic [IW-1:0] head_idx_s, tail_idx_s, fill_idx_s;
  logic          accept_s, fill_we_s, pop_s;

  ifetch_ptr_ctrl #(.DEPTH(DEPTH), .PW(PW)) u_ptr (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .pc_valid    (pc_valid),
    .imem_rvalid (imem_rvalid),
    .pop         (pop_s),
    .head        (head_s),
    .tail        (tail_s),
    .fill        (fill_s),
    .alloc       (alloc_s),
    .pc_ready    (pc_ready),
    .accept      (accept_s),
    .fill_we     (fill_we_s),
    .in_flight   (in_flight_s)
  );

  ifetch_buffer_chk #(.PW(PW)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .imem_rvalid (imem_rvalid),
    .in_flight   (in_flight_s)
  );

  // Head entry presentation and imem request pass-through
  always_comb begin
    head_idx_s  = head_s[IW-1:0];
    tail_idx_s  = tail_s[IW-1:0];
    fill_idx_s  = fill_s[IW-1:0];
    instr_valid = !reset && entries_r[head_idx_s].filled && (alloc_s != {PW{1'b0}});
    instr_data  = entries_r[head_idx_s].data;
    instr_pc    = entries_r[head_idx_s].pc;
    jump_field  = entries_r[head_idx_s].data[JUMP_FIELD_W-1:0];
    imem_req    = accept_s;
    imem_addr   = pc_in;
  end

  // Decode handshake; the pointer block ignores it during flush
  always_comb begin
    pop_s = instr_valid && instr_ready;
  end

  // Entry storage: accept claims a slot with its PC, a kept response fills it
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) entries_r[i].filled <= 1'b0;
    end else begin
      if (accept_s) begin
        entries_r[tail_idx_s].pc     <= pc_in;
        entries_r[tail_idx_s].filled <= 1'b0;
      end
      if (fill_we_s) begin
        entries_r[fill_idx_s].data   <= imem_rdata;
        entries_r[fill_idx_s].filled <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer: in-order imem model with random latency,
// expected-PC queue cleared on flush/reset, directed scenarios plus a random phase.
module tb_ifetch_buffer;
  import ifetch_pkg::*;

  localparam int TAW = 32;
  localparam int TDW = 32;

  logic           clk = 1'b0;
  logic           reset, pc_valid, flush, imem_rvalid, instr_ready;
  logic [TAW-1:0] pc_in, imem_addr, instr_pc;
  logic [TDW-1:0] imem_rdata, instr_data;
  logic           pc_ready, imem_req, instr_valid;
  logic [25:0]    jump_field;

  typedef struct { logic [TAW-1:0] pc; int acc_cyc; } exp_t;
  typedef struct { logic [TAW-1:0] pc; int due; } req_t;

  exp_t exp_q[$];
  req_t mem_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_due = 0;
  int   lat_min = 1;
  int   lat_max = 1;
  bit   check_lat = 1'b0;

  always #5 clk = ~clk;

  ifetch_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .jump_field  (jump_field)
  );

  function automatic logic [TDW-1:0] mem_word(input logic [TAW-1:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // imem model: in-order responses, each at least one cycle after its request
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_q[0].pc);
        void'(mem_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
    end
  end

  // Monitor: record accepted requests, compare every word decode takes
  initial begin
    exp_t           e;
    int             due;
    logic [TDW-1:0] w;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        mem_q.delete();
      end else begin
        if (flush) begin
          chk("flush_no_accept", imem_req, 1'b0);
          exp_q.delete();
        end else if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_instr", instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            w = mem_word(e.pc);
            chk("instr_pc", instr_pc, e.pc);
            chk("instr_data", instr_data, w);
            chk("jump_field", jump_field, w[25:0]);
            if (check_lat) chk("latency", cyc - e.acc_cyc, 2);
          end
        end
        if (imem_req) begin
          chk("imem_addr", imem_addr, pc_in);
          exp_q.push_back('{pc_in, cyc});
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mem_q.push_back('{pc_in, due});
        end
      end
    end
  end

  task automatic issue(input logic [TAW-1:0] pc, output int waits);
    pc_in    = pc;
    pc_valid = 1'b1;
    waits    = 0;
    while (1) begin
      @(negedge clk);
      if (pc_ready) break;
      waits++;
      if (waits > 50) begin
        chk("issue_timeout", waits, 0);
        break;
      end
      tick();
    end
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    instr_ready = 1'b1;
    pc_valid    = 1'b0;
    flush       = 1'b0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_done", exp_q.size() + mem_q.size(), 0);
    tick();
    @(negedge clk);
    chk("idle_valid", instr_valid, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    int acc;
    reset = 1'b1; pc_valid = 1'b1; pc_in = 32'h0; flush = 1'b0; instr_ready = 1'b1;

    // Reset held with a pending request
    repeat (2) begin
      @(negedge clk);
      chk("reset_pc_ready", pc_ready, 1'b0);
      chk("reset_imem_req", imem_req, 1'b0);
      chk("reset_instr_valid", instr_valid, 1'b0);
    end
    tick();
    reset = 1'b0;

    // Streaming PCs 0..7 with latency 1: back-to-back accepts, 2-cycle delivery
    check_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(TAW'(i), w);
      chk(i == 0 ? "first_accept_after_reset" : "stream_no_stall", w, 0);
    end
    drain();
    check_lat = 1'b0;

    // Backpressure: decode stalled, exactly DEPTH accepts
    instr_ready = 1'b0;
    acc = 0;
    pc_valid = 1'b1;
    pc_in = 32'h10;
    repeat (8) begin
      @(negedge clk);
      if (pc_ready) acc++;
      tick();
      pc_in = 32'h10 + TAW'(acc);
    end
    chk("full_accepts", acc, 4);
    @(negedge clk);
    chk("full_ready", pc_ready, 1'b0);
    tick();
    instr_ready = 1'b1;
    @(negedge clk);
    chk("pop_valid", instr_valid, 1'b1);
    chk("pop_no_bypass", pc_ready, 1'b0);
    tick();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_pop", pc_ready, 1'b1);
    tick();
    drain();

    // Flush with two requests in flight at latency 3
    lat_min = 3; lat_max = 3;
    issue(32'h20, w);
    issue(32'h21, w);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", pc_ready, 1'b0);
    tick();
    flush = 1'b0;
    pc_in = 32'h40;
    pc_valid = 1'b1;
    @(negedge clk);
    chk("post_flush_valid", instr_valid, 1'b0);
    chk("post_flush_ready", pc_ready, 1'b1);
    tick();
    drain();

    // Flush coinciding with a response and a request
    lat_min = 2; lat_max = 2;
    issue(32'h50, w);
    issue(32'h51, w);
    issue(32'h52, w);
    flush = 1'b1;
    pc_valid = 1'b1;
    pc_in = 32'h60;
    @(negedge clk);
    chk("simul_rvalid_present", imem_rvalid, 1'b1);
    chk("simul_no_req", imem_req, 1'b0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("simul_valid_cleared", instr_valid, 1'b0);
    chk("simul_ready", pc_ready, 1'b1);
    tick();
    drain();

    // Reset with three words buffered
    lat_min = 1; lat_max = 1;
    instr_ready = 1'b0;
    issue(32'h70, w);
    issue(32'h71, w);
    issue(32'h72, w);
    tick();
    tick();
    @(negedge clk);
    chk("mid_buffered_valid", instr_valid, 1'b1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_valid", instr_valid, 1'b0);
    chk("mid_reset_ready", pc_ready, 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_cleared_valid", instr_valid, 1'b0);
    chk("mid_cleared_ready", pc_ready, 1'b1);
    tick();
    instr_ready = 1'b1;
    issue(32'h80, w);
    drain();

    // Random traffic with occasional flushes and variable imem latency
    lat_min = 1; lat_max = 4;
    repeat (400) begin
      pc_valid    = ($urandom % 4) != 0;
      pc_in       = $urandom;
      instr_ready = ($urandom % 4) != 0;
      flush       = ($urandom % 16) == 0;
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
